// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-bit multiply/divide unit for the EX stage.
// It runs MULT/MULTU/DIV/DIVU into the HI/LO registers at one bit per cycle,
// asks the hazard unit to freeze the front of the pipeline while busy, and
// answers MFHI/MFLO reads for the EX result mux.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ALUOpI,
    input  logic [5:0]  functI,
    input  logic [31:0] RD1I,
    input  logic [31:0] RD2I,
    output logic        stallO,
    output logic [31:0] resultO,
    output logic        resultValidO,
    output logic [31:0] hiO,
    output logic [31:0] loO
);

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;
    localparam logic [4:0] LAST_STEP   = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of a 32-bit value, taken only when the operation is signed.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    // Two's-complement negate of a 32-bit value when requested.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        if (neg) begin
            return ~v + 32'd1;
        end else begin
            return v;
        end
    endfunction

    // Two's-complement negate of a 64-bit product when requested.
    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        if (neg) begin
            return ~v + 64'd1;
        end else begin
            return v;
        end
    endfunction

    // Architectural and iteration state
    state_t      state_r;
    logic [4:0]  count_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] acc_hi_r;     // partial product high half / partial remainder
    logic [31:0] acc_lo_r;     // multiplier being consumed / dividend becoming quotient
    logic [31:0] op_b_r;       // multiplicand magnitude or divisor magnitude
    logic [31:0] orig_rd1_r;   // dividend exactly as issued, for the divide-by-zero result
    logic        is_div_r;
    logic        neg_res_r;    // product or quotient must be negated at the end
    logic        neg_rem_r;    // remainder must be negated at the end
    logic        div_zero_r;

    // Decode results
    logic        start_s;
    logic        signed_op_s;
    logic        div_op_s;
    logic        rd_hi_s;
    logic        rd_lo_s;
    logic [31:0] abs_rd1_s;
    logic [31:0] abs_rd2_s;

    // Iteration datapath
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic        div_ge_s;
    logic [31:0] step_hi_s;
    logic [31:0] step_lo_s;

    // Final sign correction
    logic [63:0] product_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    // Decode the instruction held in ID/EX into start/read requests
    always_comb begin
        start_s     = 1'b0;
        signed_op_s = 1'b0;
        div_op_s    = 1'b0;
        rd_hi_s     = 1'b0;
        rd_lo_s     = 1'b0;
        if (ALUOpI == ALUOP_RTYPE) begin
            case (functI)
                FN_MULT: begin
                    start_s     = 1'b1;
                    signed_op_s = 1'b1;
                end
                FN_MULTU: begin
                    start_s     = 1'b1;
                end
                FN_DIV: begin
                    start_s     = 1'b1;
                    signed_op_s = 1'b1;
                    div_op_s    = 1'b1;
                end
                FN_DIVU: begin
                    start_s     = 1'b1;
                    div_op_s    = 1'b1;
                end
                FN_MFHI: begin
                    rd_hi_s     = 1'b1;
                end
                FN_MFLO: begin
                    rd_lo_s     = 1'b1;
                end
                default: begin
                    start_s     = 1'b0;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end
    end

    // Operand magnitudes captured at issue
    always_comb begin
        abs_rd1_s = abs32(RD1I, signed_op_s);
        abs_rd2_s = abs32(RD2I, signed_op_s);
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, op_b_r} : 33'd0);
        div_shift_s = {acc_hi_r, acc_lo_r[31]};
        div_ge_s    = (div_shift_s >= {1'b0, op_b_r});
        if (is_div_r) begin
            if (div_ge_s) begin
                // Remainder is below the divisor, so it always fits in 32 bits.
                step_hi_s = div_shift_s[31:0] - op_b_r;
                step_lo_s = {acc_lo_r[30:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[31:0];
                step_lo_s = {acc_lo_r[30:0], 1'b0};
            end
        end else begin
            // Shift the 65-bit {carry, hi, lo} right by one after the add.
            step_hi_s = mul_sum_s[32:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[31:1]};
        end
    end

    // Sign correction of the finished magnitude result
    always_comb begin
        product_s = cond_neg64({acc_hi_r, acc_lo_r}, neg_res_r);
        if (is_div_r) begin
            if (div_zero_r) begin
                fix_hi_s = orig_rd1_r;
                fix_lo_s = 32'hFFFF_FFFF;
            end else begin
                fix_hi_s = cond_neg32(acc_hi_r, neg_rem_r);
                fix_lo_s = cond_neg32(acc_lo_r, neg_res_r);
            end
        end else begin
            fix_hi_s = product_s[63:32];
            fix_lo_s = product_s[31:0];
        end
    end

    // Control FSM with operand capture, iteration and HI/LO write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= 5'd0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            acc_hi_r   <= 32'd0;
            acc_lo_r   <= 32'd0;
            op_b_r     <= 32'd0;
            orig_rd1_r <= 32'd0;
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_BUSY;
                        count_r    <= 5'd0;
                        acc_hi_r   <= 32'd0;
                        orig_rd1_r <= RD1I;
                        is_div_r   <= div_op_s;
                        neg_res_r  <= signed_op_s & (RD1I[31] ^ RD2I[31]);
                        neg_rem_r  <= signed_op_s & RD1I[31];
                        div_zero_r <= div_op_s & (RD2I == 32'd0);
                        if (div_op_s) begin
                            op_b_r   <= abs_rd2_s;
                            acc_lo_r <= abs_rd1_s;
                        end else begin
                            op_b_r   <= abs_rd1_s;
                            acc_lo_r <= abs_rd2_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    if (count_r == LAST_STEP) begin
                        state_r <= ST_FIX;
                        count_r <= 5'd0;
                    end else begin
                        state_r <= ST_BUSY;
                        count_r <= count_r + 5'd1;
                    end
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    // The finished start op is still on the inputs; let it pass.
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall request and MFHI/MFLO read port
    always_comb begin
        stallO       = 1'b0;
        resultO      = 32'd0;
        resultValidO = 1'b0;
        if (!rst_n) begin
            stallO       = 1'b0;
            resultO      = 32'd0;
            resultValidO = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stallO = start_s;
                    if (rd_hi_s) begin
                        resultO      = hi_r;
                        resultValidO = 1'b1;
                    end else if (rd_lo_s) begin
                        resultO      = lo_r;
                        resultValidO = 1'b1;
                    end else begin
                        resultO      = 32'd0;
                        resultValidO = 1'b0;
                    end
                end
                ST_BUSY: begin
                    stallO = 1'b1;
                end
                ST_FIX: begin
                    stallO = 1'b1;
                end
                ST_DONE: begin
                    stallO = 1'b0;
                end
                default: begin
                    stallO = 1'b0;
                end
            endcase
        end
    end

    assign hiO = hi_r;
    assign loO = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a cycle-level behavioural model of the unit
// is compared against the DUT on every falling edge, and the results of the
// directed operations are also checked against hand-computed literals.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ALUOpI;
    logic [5:0]  functI;
    logic [31:0] RD1I;
    logic [31:0] RD2I;
    logic        stallO;
    logic [31:0] resultO;
    logic        resultValidO;
    logic [31:0] hiO;
    logic [31:0] loO;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state: m_cnt is the cycle index since issue (0 = idle, 1..33 stalled, 34 = pipeline advances)
    int          m_cnt;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          n;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALUOpI       (ALUOpI),
        .functI       (functI),
        .RD1I         (RD1I),
        .RD2I         (RD2I),
        .stallO       (stallO),
        .resultO      (resultO),
        .resultValidO (resultValidO),
        .hiO          (hiO),
        .loO          (loO)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic dec_start(input logic [1:0] op, input logic [5:0] fn);
        return (op == 2'b10) && (fn == 6'h18 || fn == 6'h19 || fn == 6'h1A || fn == 6'h1B);
    endfunction

    // Architectural result {HI, LO} computed with plain arithmetic
    function automatic logic [63:0] model_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        p  = 64'd0;
        case (fn)
            6'h18: p = 64'(sa * sb);
            6'h19: p = {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            6'h1B: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    function automatic logic exp_stall_f();
        if (!rst_n) return 1'b0;
        if (m_cnt == 0) return dec_start(ALUOpI, functI);
        return (m_cnt >= 1) && (m_cnt <= 33);
    endfunction

    function automatic logic [31:0] exp_res_f();
        if (!rst_n || m_cnt != 0 || ALUOpI != 2'b10) return 32'd0;
        if (functI == 6'h10) return m_hi;
        if (functI == 6'h12) return m_lo;
        return 32'd0;
    endfunction

    function automatic logic exp_valid_f();
        return rst_n && (m_cnt == 0) && (ALUOpI == 2'b10) && (functI == 6'h10 || functI == 6'h12);
    endfunction

    // Behavioural timing model: 34 stalled cycles, HI/LO land at the end of cycle 33
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_pend <= 64'd0;
        end else if (m_cnt == 0) begin
            if (dec_start(ALUOpI, functI)) begin
                m_cnt  <= 1;
                m_pend <= model_op(functI, RD1I, RD2I);
            end
        end else if (m_cnt == 33) begin
            m_hi  <= m_pend[63:32];
            m_lo  <= m_pend[31:0];
            m_cnt <= 34;
        end else if (m_cnt == 34) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stall",  32'(stallO),       32'(exp_stall_f()));
            chk("result", resultO,           exp_res_f());
            chk("valid",  32'(resultValidO), 32'(exp_valid_f()));
            chk("hi",     hiO,               m_hi);
            chk("lo",     loO,               m_lo);
        end
    end

    // Present one instruction in ID/EX and hold it while the unit stalls
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b, output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        @(posedge clk);
        #1;
        ALUOpI = op;
        functI = fn;
        RD1I   = a;
        RD2I   = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stallO) stalls++;
            else        done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: stall still %b after 100 cycles, required release", stallO);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ALUOpI = 2'b10;
        functI = 6'h18;
        RD1I   = 32'd3;
        RD2I   = 32'd4;
        repeat (2) @(negedge clk);
        // Reset state with a start op on the inputs: no stall allowed
        chk("rst_stall", 32'(stallO), 32'd0);
        chk("rst_hi",    hiO,         32'd0);
        chk("rst_lo",    loO,         32'd0);
        functI = 6'h10;
        #1;
        chk("rst_valid",  32'(resultValidO), 32'd0);
        chk("rst_result", resultO,           32'd0);
        cmp_en = 1'b1;
        ALUOpI = 2'b00;
        functI = 6'h00;
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("multu_stall", 32'(n), 32'd34);
        chk("multu_hi", hiO, 32'hFFFF_FFFE);
        chk("multu_lo", loO, 32'h0000_0001);

        run_instr(2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7, n);
        chk("mult_stall", 32'(n), 32'd34);
        chk("mult_hi", hiO, 32'hFFFF_FFFF);
        chk("mult_lo", loO, 32'hFFFF_FFEB);

        run_instr(2'b10, 6'h12, 32'd0, 32'd0, n);
        chk("mflo_stall",  32'(n), 32'd0);
        chk("mflo_result", resultO, 32'hFFFF_FFEB);
        chk("mflo_valid",  32'(resultValidO), 32'd1);

        run_instr(2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_lo", loO, 32'hFFFF_FFFD);
        chk("div_hi", hiO, 32'hFFFF_FFFF);

        run_instr(2'b10, 6'h1B, 32'd100, 32'd7, n);
        chk("divu_lo", loO, 32'd14);
        chk("divu_hi", hiO, 32'd2);

        run_instr(2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("divovf_lo", loO, 32'h8000_0000);
        chk("divovf_hi", hiO, 32'd0);

        run_instr(2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd0, n);
        chk("div0s_lo", loO, 32'hFFFF_FFFF);
        chk("div0s_hi", hiO, 32'hFFFF_FFF9);

        run_instr(2'b10, 6'h1B, 32'h0000_1234, 32'd0, n);
        chk("divu0_stall", 32'(n), 32'd34);
        chk("divu0_lo", loO, 32'hFFFF_FFFF);
        chk("divu0_hi", hiO, 32'h0000_1234);

        run_instr(2'b10, 6'h10, 32'd0, 32'd0, n);
        chk("mfhi_result", resultO, 32'h0000_1234);

        // Non-start instructions must neither stall nor touch HI/LO
        run_instr(2'b10, 6'h20, 32'd5, 32'd6, n);
        chk("add_stall", 32'(n), 32'd0);
        run_instr(2'b00, 6'h18, 32'd5, 32'd6, n);
        chk("aluop_stall", 32'(n), 32'd0);
        run_instr(2'b01, 6'h10, 32'd0, 32'd0, n);
        chk("aluop_rd_valid", 32'(resultValidO), 32'd0);
        run_instr(2'b00, 6'h00, 32'd0, 32'd0, n);
        chk("nostart_hi", hiO, 32'h0000_1234);
        chk("nostart_lo", loO, 32'hFFFF_FFFF);

        // Reset in the middle of an operation abandons it
        @(posedge clk);
        #1;
        ALUOpI = 2'b10;
        functI = 6'h19;
        RD1I   = 32'd5;
        RD2I   = 32'd5;
        repeat (10) @(posedge clk);
        #2;
        chk("midop_busy", 32'(stallO), 32'd1);
        #1;
        rst_n  = 1'b0;
        ALUOpI = 2'b00;
        functI = 6'h00;
        #1;
        chk("midop_stall", 32'(stallO), 32'd0);
        chk("midop_hi",    hiO,         32'd0);
        chk("midop_lo",    loO,         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_instr(2'b10, 6'h1B, 32'd9, 32'd3, n);
        chk("post_rst_stall", 32'(n), 32'd34);
        chk("post_rst_lo", loO, 32'd3);
        chk("post_rst_hi", hiO, 32'd0);

        run_instr(2'b00, 6'h00, 32'd0, 32'd0, n);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
